// File: rtl/servo_slew_ctrl.sv
// servo_slew_ctrl
// APB3-mapped slew-rate limiter for two hobby-servo PWM channels (pan, tilt).
// Software writes angle targets. Once per PWM frame, each channel's pulse
// width moves toward its target by at most STEP cycles. A single shared
// compare/step datapath serves both channels through a small
// IDLE -> UPD1 -> UPD2 sequencer.
//
// Ports:
//   PCLK, PRESERN              clock, asynchronous active-low reset
//   PSEL/PENABLE/PWRITE/PADDR/PWDATA/PRDATA/PREADY/PSLVERR
//                              APB3 slave, zero wait states, only PADDR[7:0] decoded
//   pulse_width1/2             ramped pan/tilt pulse widths feeding the pwm generators
//   frame_tick                 one-cycle pulse at each frame boundary
//   irq                        settle interrupt (tied 0 unless the macro is defined)
//
// Register map (PADDR[7:0]):
//   0x00 CTRL    [0] EN
//   0x10 TARGET1 write [10:0] angle code; read clamped 18-bit pulse width
//   0x14 TARGET2 same as TARGET1, for the tilt channel
//   0x18 STEP    [17:0] maximum change per frame (0 = jump straight to target)
//   0x1C STATUS  RO [0] busy1, [1] busy2, [2] seq_active
//   0x20 IRQ     [0] settle_pend (W1C), [1] settle_ie -- only with SERVO_SLEW_IRQ_EN
//
// Build option: define SERVO_SLEW_IRQ_EN to include the settle interrupt logic.
module servo_slew_ctrl #(
  parameter int PERIOD       = 2000000,
  parameter int MIN_PW       = 60000,
  parameter int MAX_PW       = 240000,
  parameter int SCALE        = 100,
  parameter int DEFAULT_STEP = 1000
) (
  input  logic        PCLK,
  input  logic        PRESERN,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [31:0] PADDR,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR,
  output logic [17:0] pulse_width1,
  output logic [17:0] pulse_width2,
  output logic        frame_tick,
  output logic        irq
);

  localparam int             CW       = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(PERIOD - 1);
  localparam logic [17:0]    MIN_PW18 = 18'(MIN_PW);
  localparam logic [17:0]    MAX_PW18 = 18'(MAX_PW);

  typedef enum logic [1:0] {IDLE, UPD1, UPD2} state_t;

  state_t         state_q, state_d;
  logic           en_q;
  logic [17:0]    tgt1_q, tgt2_q;
  logic [17:0]    step_q;
  logic [17:0]    step_act_q;   // STEP snapshot used for the whole frame's sequence
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           tick_q, tick_d;
  logic [17:0]    pw1_q, pw1_d, pw2_q, pw2_d;

  logic           wr_en;
  logic [7:0]     addr;
  logic [19:0]    tgt_raw;
  logic [17:0]    tgt_new;
  logic           busy1, busy2;
  logic [17:0]    dp_cur, dp_tgt, dp_dist, dp_next;
  logic           dp_up;
  logic           unused_ok;

  assign wr_en     = PSEL & PENABLE & PWRITE;
  assign addr      = PADDR[7:0];
  assign unused_ok = ^{PADDR[31:8], PWDATA[31:18]};

  assign PREADY  = 1'b1;
  assign PSLVERR = 1'b0;

  // 20-bit target arithmetic so the largest code (2047) cannot wrap before clamping.
  assign tgt_raw = 20'(MIN_PW) + 20'(SCALE) * {9'd0, PWDATA[10:0]};
  assign tgt_new = (tgt_raw > 20'(MAX_PW)) ? MAX_PW18 : tgt_raw[17:0];

  assign busy1 = (pw1_q != tgt1_q);
  assign busy2 = (pw2_q != tgt2_q);

  assign pulse_width1 = pw1_q;
  assign pulse_width2 = pw2_q;
  assign frame_tick   = tick_q;

  // Shared datapath: the channel is selected by the sequencer state. When the
  // remaining distance fits in one step, land exactly on the target.
  always_comb begin
    dp_cur  = (state_q == UPD2) ? pw2_q  : pw1_q;
    dp_tgt  = (state_q == UPD2) ? tgt2_q : tgt1_q;
    dp_up   = (dp_tgt >= dp_cur);
    dp_dist = dp_up ? (dp_tgt - dp_cur) : (dp_cur - dp_tgt);
    if ((step_act_q == 18'd0) || (dp_dist <= step_act_q)) begin
      dp_next = dp_tgt;
    end else if (dp_up) begin
      dp_next = dp_cur + step_act_q;
    end else begin
      dp_next = dp_cur - step_act_q;
    end
  end

  // Frame counter and tick; the counter is parked at 0 while disabled.
  always_comb begin
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    if (!en_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d  = '0;
      tick_d = 1'b1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Sequencer: runs to completion once started, independent of EN.
  always_comb begin
    state_d = state_q;
    pw1_d   = pw1_q;
    pw2_d   = pw2_q;
    case (state_q)
      IDLE: if (tick_q) state_d = UPD1;
      UPD1: begin
        pw1_d   = dp_next;
        state_d = UPD2;
      end
      UPD2: begin
        pw2_d   = dp_next;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESERN) begin
    if (!PRESERN) begin
      state_q    <= IDLE;
      en_q       <= 1'b0;
      tgt1_q     <= MIN_PW18;
      tgt2_q     <= MIN_PW18;
      step_q     <= 18'(DEFAULT_STEP);
      step_act_q <= 18'(DEFAULT_STEP);
      cnt_q      <= '0;
      tick_q     <= 1'b0;
      pw1_q      <= MIN_PW18;
      pw2_q      <= MIN_PW18;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tick_q  <= tick_d;
      pw1_q   <= pw1_d;
      pw2_q   <= pw2_d;
      // Snapshot at the tick so STEP writes during UPD1/UPD2 wait for the next frame.
      if (tick_q) step_act_q <= step_q;
      if (wr_en) begin
        case (addr)
          8'h00:   en_q   <= PWDATA[0];
          8'h10:   tgt1_q <= tgt_new;
          8'h14:   tgt2_q <= tgt_new;
          8'h18:   step_q <= PWDATA[17:0];
          default: ;
        endcase
      end
    end
  end

`ifdef SERVO_SLEW_IRQ_EN
  logic pend_q, pend_d, ie_q, ie_d;
  logic pre_busy_q;   // busy1|busy2 as seen at the start of this sequence
  logic settle_set;

  assign settle_set = (state_q == UPD2) && pre_busy_q && !busy1 && (dp_next == tgt2_q);

  always_comb begin
    pend_d = pend_q;
    ie_d   = ie_q;
    if (wr_en && (addr == 8'h20)) begin
      if (PWDATA[0]) pend_d = 1'b0;
      ie_d = PWDATA[1];
    end
    if (settle_set) pend_d = 1'b1;   // set beats a coincident clear
  end

  always_ff @(posedge PCLK or negedge PRESERN) begin
    if (!PRESERN) begin
      pend_q     <= 1'b0;
      ie_q       <= 1'b0;
      pre_busy_q <= 1'b0;
    end else begin
      pend_q <= pend_d;
      ie_q   <= ie_d;
      if (state_q == UPD1) pre_busy_q <= busy1 | busy2;
    end
  end

  assign irq = pend_q & ie_q;
`else
  assign irq = 1'b0;
`endif

  // Combinational read mux; anything but a selected read returns 0.
  always_comb begin
    PRDATA = 32'd0;
    if (PSEL && !PWRITE) begin
      case (addr)
        8'h00:   PRDATA = {31'd0, en_q};
        8'h10:   PRDATA = {14'd0, tgt1_q};
        8'h14:   PRDATA = {14'd0, tgt2_q};
        8'h18:   PRDATA = {14'd0, step_q};
        8'h1C:   PRDATA = {29'd0, (state_q != IDLE), busy2, busy1};
`ifdef SERVO_SLEW_IRQ_EN
        8'h20:   PRDATA = {30'd0, ie_q, pend_q};
`endif
        default: PRDATA = 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_servo_slew_ctrl.sv
module tb_servo_slew_ctrl;
  localparam int PERIOD   = 100;
  localparam int MIN_PW   = 60000;
  localparam int MAX_PW   = 240000;
  localparam int SCALE    = 100;
  localparam int DEF_STEP = 1000;

  logic        PCLK = 1'b0;
  logic        PRESERN = 1'b0;
  logic        PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
  logic [31:0] PADDR = 32'd0, PWDATA = 32'd0;
  logic [31:0] PRDATA;
  logic        PREADY, PSLVERR;
  logic [17:0] pulse_width1, pulse_width2;
  logic        frame_tick, irq;

  servo_slew_ctrl #(
    .PERIOD(PERIOD), .MIN_PW(MIN_PW), .MAX_PW(MAX_PW),
    .SCALE(SCALE), .DEFAULT_STEP(DEF_STEP)
  ) dut (
    .PCLK(PCLK), .PRESERN(PRESERN), .PSEL(PSEL), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
    .PREADY(PREADY), .PSLVERR(PSLVERR), .pulse_width1(pulse_width1),
    .pulse_width2(pulse_width2), .frame_tick(frame_tick), .irq(irq)
  );

  always #5 PCLK = ~PCLK;

  int errors = 0;
  int checks = 0;

  // Reference model state: current widths, targets, step, interrupt bits.
  int m_pw1, m_pw2, m_t1, m_t2, m_step;
  bit m_pend, m_ie;

  function automatic int tgt_of(input int code);
    int t;
    t = MIN_PW + SCALE * code;
    return (t > MAX_PW) ? MAX_PW : t;
  endfunction

  function automatic int slew(input int cur, input int tgt, input int step);
    int d;
    d = (tgt > cur) ? tgt - cur : cur - tgt;
    if (step == 0 || d <= step) return tgt;
    return (tgt > cur) ? cur + step : cur - step;
  endfunction

  task automatic apb_write(input logic [7:0] a, input logic [31:0] d);
    PSEL = 1'b1; PWRITE = 1'b1; PENABLE = 1'b0;
    PADDR = {24'h5A5A00, a}; PWDATA = d;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_read(input logic [7:0] a, output logic [31:0] d);
    PSEL = 1'b1; PWRITE = 1'b0; PENABLE = 1'b0; PADDR = {24'hC0DE00, a};
    #1;
    d = PRDATA;
    PSEL = 1'b0; PADDR = 32'd0;
  endtask

  task automatic set_target(input int ch, input logic [31:0] d);
    apb_write((ch == 1) ? 8'h10 : 8'h14, d);
    if (ch == 1) m_t1 = tgt_of(int'(d[10:0]));
    else         m_t2 = tgt_of(int'(d[10:0]));
  endtask

  task automatic set_step(input logic [31:0] d);
    apb_write(8'h18, d);
    m_step = int'(d[17:0]);
  endtask

  task automatic wait_tick(output bit got);
    got = 1'b0;
    for (int i = 0; i < 2 * PERIOD + 10; i++) begin
      @(posedge PCLK); #1;
      if (frame_tick === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  // One frame: wait for the tick (cycle T), check pw1 at T+2 and pw2 at T+3.
  // Optionally writes TARGET1 so that its write lands in the UPD1 cycle.
  task automatic run_frame(input bit wr_upd1, input logic [31:0] wdata);
    logic [31:0] rd;
    bit got, pre;
    int e1, e2, old1, old2;
    old1 = m_pw1; old2 = m_pw2;
    pre  = (m_pw1 != m_t1) || (m_pw2 != m_t2);
    e1   = slew(m_pw1, m_t1, m_step);
    e2   = slew(m_pw2, m_t2, m_step);
    wait_tick(got);
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL frame_tick_timeout: got no tick within %0d cycles, required one", 2 * PERIOD + 10);
      return;
    end
    if (wr_upd1) begin
      apb_write(8'h10, wdata);
    end else begin
      @(posedge PCLK); #1;
      checks++;
      if (pulse_width1 !== 18'(old1)) begin
        errors++;
        $display("FAIL pw1_early: got %0d at T+1, required %0d", pulse_width1, old1);
      end
      apb_read(8'h1C, rd);
      checks++;
      if (rd[2] !== 1'b1) begin
        errors++;
        $display("FAIL seq_active: got %0b at T+1, required 1", rd[2]);
      end
      @(posedge PCLK); #1;
    end
    checks++;
    if (pulse_width1 !== 18'(e1)) begin
      errors++;
      $display("FAIL pw1_update: got %0d at T+2, required %0d", pulse_width1, e1);
    end
    checks++;
    if (pulse_width2 !== 18'(old2)) begin
      errors++;
      $display("FAIL pw2_early: got %0d at T+2, required %0d", pulse_width2, old2);
    end
    @(posedge PCLK); #1;
    checks++;
    if (pulse_width2 !== 18'(e2)) begin
      errors++;
      $display("FAIL pw2_update: got %0d at T+3, required %0d", pulse_width2, e2);
    end
    m_pw1 = e1; m_pw2 = e2;
    if (wr_upd1) m_t1 = tgt_of(int'(wdata[10:0]));
    if (pre && m_pw1 == m_t1 && m_pw2 == m_t2) m_pend = 1'b1;
    checks++;
    if (irq !== (m_pend & m_ie)) begin
      errors++;
      $display("FAIL irq_frame: got %b, required %b", irq, m_pend & m_ie);
    end
    apb_read(8'h1C, rd);
    checks++;
    if (rd !== {29'd0, 1'b0, (m_pw2 != m_t2), (m_pw1 != m_t1)}) begin
      errors++;
      $display("FAIL status_frame: got 0x%0h, required busy1=%0b busy2=%0b seq=0",
               rd, m_pw1 != m_t1, m_pw2 != m_t2);
    end
    $display("frame: pw1=%0d pw2=%0d tgt1=%0d tgt2=%0d step=%0d", e1, e2, m_t1, m_t2, m_step);
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    PRESERN = 1'b0;
    m_pw1 = MIN_PW; m_pw2 = MIN_PW; m_t1 = MIN_PW; m_t2 = MIN_PW;
    m_step = DEF_STEP; m_pend = 1'b0; m_ie = 1'b0;
    repeat (3) @(posedge PCLK);
    #1;
    checks++;
    if (pulse_width1 !== 18'(MIN_PW) || pulse_width2 !== 18'(MIN_PW)) begin
      errors++;
      $display("FAIL reset_pw: got %0d/%0d, required %0d", pulse_width1, pulse_width2, MIN_PW);
    end
    checks++;
    if (frame_tick !== 1'b0 || irq !== 1'b0 || PREADY !== 1'b1 || PSLVERR !== 1'b0) begin
      errors++;
      $display("FAIL reset_outs: got tick=%b irq=%b ready=%b slverr=%b, required 0 0 1 0",
               frame_tick, irq, PREADY, PSLVERR);
    end
    apb_read(8'h1C, rd);
    checks++;
    if (rd !== 32'd0) begin errors++; $display("FAIL reset_status: got 0x%0h, required 0", rd); end
    apb_read(8'h18, rd);
    checks++;
    if (rd !== 32'(DEF_STEP)) begin errors++; $display("FAIL reset_step: got %0d, required %0d", rd, DEF_STEP); end
    apb_read(8'h10, rd);
    checks++;
    if (rd !== 32'(MIN_PW)) begin errors++; $display("FAIL reset_tgt1: got %0d, required %0d", rd, MIN_PW); end
    apb_read(8'h00, rd);
    checks++;
    if (rd !== 32'd0) begin errors++; $display("FAIL reset_ctrl: got 0x%0h, required 0", rd); end
    $display("reset: pw1=%0d pw2=%0d", pulse_width1, pulse_width2);
    PRESERN = 1'b1;
    @(posedge PCLK); #1;
  endtask

  task automatic test_ramp_up();
    logic [31:0] rd;
    set_step(32'd10000);
    set_target(1, 32'd600);
    apb_read(8'h10, rd);
    checks++;
    if (rd !== 32'd120000) begin errors++; $display("FAIL ramp_tgt1: got %0d, required 120000", rd); end
    apb_write(8'h00, 32'd1);
    for (int i = 1; i <= 6; i++) begin
      run_frame(1'b0, 32'd0);
      checks++;
      if (pulse_width1 !== 18'(60000 + 10000 * i)) begin
        errors++;
        $display("FAIL ramp_up_%0d: got %0d, required %0d", i, pulse_width1, 60000 + 10000 * i);
      end
    end
  endtask

  task automatic test_clamp();
    logic [31:0] rd;
    set_target(2, 32'd2047);
    apb_read(8'h14, rd);
    checks++;
    if (rd !== 32'd240000) begin errors++; $display("FAIL clamp_tgt2: got %0d, required 240000", rd); end
    set_step(32'd0);
    run_frame(1'b0, 32'd0);
    checks++;
    if (pulse_width2 !== 18'd240000) begin
      errors++;
      $display("FAIL clamp_jump: got %0d, required 240000", pulse_width2);
    end
  endtask

  task automatic test_ramp_down();
    int exp_pw[4] = '{95000, 70000, 60000, 60000};
    set_step(32'd25000);
    set_target(1, 32'd0);
    for (int i = 0; i < 4; i++) begin
      run_frame(1'b0, 32'd0);
      checks++;
      if (pulse_width1 !== 18'(exp_pw[i])) begin
        errors++;
        $display("FAIL ramp_down_%0d: got %0d, required %0d", i, pulse_width1, exp_pw[i]);
      end
    end
  endtask

  task automatic test_mid_update();
    logic [31:0] rd;
    logic [17:0] hold1, hold2;
    bit ticked;
    set_step(32'd10000);
    set_target(1, 32'd400);
    run_frame(1'b0, 32'd0);
    run_frame(1'b1, 32'd0);
    checks++;
    if (pulse_width1 !== 18'd80000) begin
      errors++;
      $display("FAIL upd1_write_old: got %0d, required 80000", pulse_width1);
    end
    run_frame(1'b0, 32'd0);
    checks++;
    if (pulse_width1 !== 18'd70000) begin
      errors++;
      $display("FAIL upd1_write_new: got %0d, required 70000", pulse_width1);
    end
    set_target(1, 32'd2047);
    run_frame(1'b0, 32'd0);
    apb_write(8'h00, 32'd0);
    hold1 = pulse_width1; hold2 = pulse_width2;
    ticked = 1'b0;
    for (int i = 0; i < 3 * PERIOD; i++) begin
      @(posedge PCLK); #1;
      if (frame_tick !== 1'b0) ticked = 1'b1;
    end
    checks++;
    if (ticked || pulse_width1 !== hold1 || pulse_width2 !== hold2) begin
      errors++;
      $display("FAIL en_off_freeze: got tick=%b pw1=%0d pw2=%0d, required tick=0 pw1=%0d pw2=%0d",
               ticked, pulse_width1, pulse_width2, hold1, hold2);
    end
    apb_read(8'h1C, rd);
    checks++;
    if (rd !== 32'd1) begin errors++; $display("FAIL en_off_status: got 0x%0h, required 0x1", rd); end
    $display("en_off: pw1=%0d pw2=%0d held", pulse_width1, pulse_width2);
    apb_write(8'h00, 32'd1);
  endtask

  task automatic test_random();
    logic [31:0] rd;
    for (int it = 0; it < 5; it++) begin
      set_target(1, $urandom);
      set_target(2, $urandom);
      set_step((32'($urandom) << 18) | 32'($urandom_range(0, 40000)));
      apb_read(8'h14, rd);
      checks++;
      if (rd !== 32'(m_t2)) begin errors++; $display("FAIL rand_tgt2: got %0d, required %0d", rd, m_t2); end
      for (int f = 0; f < 3; f++) run_frame(1'b0, 32'd0);
    end
  endtask

  task automatic test_regs();
    logic [31:0] rd;
    apb_write(8'h04, 32'hFFFF_FFFF);
    apb_write(8'h1C, 32'hFFFF_FFFF);
    apb_read(8'h04, rd);
    checks++;
    if (rd !== 32'd0) begin errors++; $display("FAIL unmapped_read: got 0x%0h, required 0", rd); end
    apb_read(8'h00, rd);
    checks++;
    if (rd !== 32'd1) begin errors++; $display("FAIL ctrl_read: got 0x%0h, required 0x1", rd); end
    PSEL = 1'b1; PWRITE = 1'b1; PADDR = 32'h18; #1;
    checks++;
    if (PRDATA !== 32'd0) begin errors++; $display("FAIL nonread_prdata: got 0x%0h, required 0", PRDATA); end
    PSEL = 1'b0; PWRITE = 1'b0; PADDR = 32'd0;
    $display("regs: unmapped/non-read checked");
  endtask

  task automatic test_irq();
    logic [31:0] rd;
`ifdef SERVO_SLEW_IRQ_EN
    apb_write(8'h20, 32'd3);   // enable and clear anything pending
    m_ie = 1'b1; m_pend = 1'b0;
    set_step(32'd0);
    set_target(1, 32'd1000);
    set_target(2, 32'd10);
    run_frame(1'b0, 32'd0);
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL irq_settle: got %b, required 1", irq); end
    apb_write(8'h20, 32'd3);
    m_pend = 1'b0;
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_w1c: got %b, required 0", irq); end
    apb_read(8'h20, rd);
    checks++;
    if (rd !== 32'd2) begin errors++; $display("FAIL irq_reg: got 0x%0h, required 0x2", rd); end
`else
    apb_write(8'h20, 32'd3);
    apb_read(8'h20, rd);
    checks++;
    if (rd !== 32'd0) begin errors++; $display("FAIL irq_absent_reg: got 0x%0h, required 0", rd); end
    set_step(32'd0);
    set_target(1, 32'd1000);
    run_frame(1'b0, 32'd0);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_absent: got %b, required 0", irq); end
`endif
    $display("irq: checked, irq=%b", irq);
  endtask

  task automatic test_async_reset();
    logic [31:0] rd;
    set_step(32'd1000);
    set_target(1, 32'd2047);
    set_target(2, 32'd0);
    run_frame(1'b0, 32'd0);
    @(posedge PCLK); #3;
    PRESERN = 1'b0;
    #1;
    checks++;
    if (pulse_width1 !== 18'(MIN_PW) || pulse_width2 !== 18'(MIN_PW) || frame_tick !== 1'b0 || irq !== 1'b0) begin
      errors++;
      $display("FAIL async_reset_outs: got pw1=%0d pw2=%0d tick=%b irq=%b, required %0d %0d 0 0",
               pulse_width1, pulse_width2, frame_tick, irq, MIN_PW, MIN_PW);
    end
    apb_read(8'h18, rd);
    checks++;
    if (rd !== 32'(DEF_STEP)) begin errors++; $display("FAIL async_reset_step: got %0d, required %0d", rd, DEF_STEP); end
    apb_read(8'h00, rd);
    checks++;
    if (rd !== 32'd0) begin errors++; $display("FAIL async_reset_ctrl: got 0x%0h, required 0", rd); end
    $display("async_reset: pw1=%0d pw2=%0d", pulse_width1, pulse_width2);
    @(posedge PCLK); #1;
    PRESERN = 1'b1;
  endtask

  initial begin
    test_reset();
    test_ramp_up();
    test_clamp();
    test_ramp_down();
    test_mid_update();
    test_regs();
    test_random();
    test_irq();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
